// File: rtl/ysyx_25030093_pcgen_pkg.sv
// Shared types for the PC generator: commit next-PC selector, FSM states and
// the fixed instruction length.
package ysyx_25030093_pc_pkg;

    localparam int ILEN_BYTES = 4;

    typedef enum logic [2:0] {
        PC_JALR = 3'b001,
        PC_JAL  = 3'b010,
        PC_BR   = 3'b100,
        PC_CSR  = 3'b101,
        PC_SEQ  = 3'b110
    } cmt_kind_e;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } pcgen_state_e;

endpackage

// File: rtl/ysyx_25030093_pcgen_if.sv
// Fetch request and commit bundle between the PC generator (master) and the
// IFU/EXU side (slave).
interface ysyx_25030093_pcgen_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic            cmt_valid;
    logic [2:0]      cmt_kind;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] imm_data;
    logic [XLEN-1:0] csr_pc;
    logic            br_taken;
    logic            cmt_call;
    logic            cmt_ret;

    modport master (
        output out_valid, out_pc,
        input  out_ready, cmt_valid, cmt_kind, rs1_data, imm_data, csr_pc,
               br_taken, cmt_call, cmt_ret
    );

    modport slave (
        input  out_valid, out_pc,
        output out_ready, cmt_valid, cmt_kind, rs1_data, imm_data, csr_pc,
               br_taken, cmt_call, cmt_ret
    );
endinterface

// File: rtl/ysyx_25030093_ras.sv
// Return-address stack as a circular buffer; pushing when full overwrites the
// oldest entry, popping when empty leaves the pointers alone.
module ysyx_25030093_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            valid
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(RAS_DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

    logic [XLEN-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]   sp;
    logic [PW-1:0]   sp_top;
    logic [PW-1:0]   sp_pop;
    logic [PW:0]     cnt;
    logic [PW:0]     cnt_pop;

    // sp is the next free slot, so the top entry sits just below it
    assign sp_top = sp - PW'(1);
    assign valid  = (cnt != '0);
    assign top    = valid ? stack[sp_top] : '0;

    // a simultaneous pop+push is resolved as pop first, then push
    always_comb begin
        sp_pop  = sp;
        cnt_pop = cnt;
        if (pop && valid) begin
            sp_pop  = sp_top;
            cnt_pop = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp  <= '0;
            cnt <= '0;
        end else if (push) begin
            sp  <= sp_pop + PW'(1);
            cnt <= (cnt_pop == CNT_FULL) ? cnt_pop : cnt_pop + CNT_ONE;
        end else begin
            sp  <= sp_pop;
            cnt <= cnt_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            stack[sp_pop] <= push_data;
        end
    end

endmodule

// File: rtl/ysyx_25030093_pcgen.sv
// PC generator: issues one fetch at a time, computes the next PC on commit,
// and predicts/audits return targets through a small RAS.
//
//   state    | meaning
//   ST_ISSUE | fetch request offered (unless halted), waiting for handshake
//   ST_WAIT  | fetch accepted, waiting for EXU commit of out_pc
module ysyx_25030093_pcgen
    import ysyx_25030093_pc_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    ysyx_25030093_pcgen_if.master  bus,
    output logic [XLEN-1:0]        ras_top,
    output logic                   ras_valid,
    output logic [31:0]            ret_mispred
);
    pcgen_state_e    state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] pc_nxt;
    logic            issue_ok;
    logic            commit;
    logic            mispred;

    assign pc_seq = pc + XLEN'(ILEN_BYTES);
    assign pc_rel = pc + bus.imm_data;

    always_comb begin
        pc_nxt = pc;
        case (cmt_kind_e'(bus.cmt_kind))
            PC_JALR: pc_nxt = (bus.rs1_data + bus.imm_data) & ~XLEN'(1);
            PC_JAL:  pc_nxt = pc_rel;
            PC_BR:   pc_nxt = bus.br_taken ? pc_rel : pc_seq;
            PC_CSR:  pc_nxt = bus.csr_pc;
            PC_SEQ:  pc_nxt = pc_seq;
            default: pc_nxt = pc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        issue_ok  = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_ISSUE: begin
                issue_ok = !halt;
                if (issue_ok && bus.out_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.cmt_valid) begin
                    commit    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
        endcase
    end

    // rst is active-low, so gating with it silences the request during reset
    assign bus.out_valid = rst & issue_ok;
    assign bus.out_pc    = pc;

    // compared against the pre-pop top, i.e. the entry this return consumes
    assign mispred = bus.cmt_ret && (!ras_valid || (ras_top != pc_nxt));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_ISSUE;
            pc          <= XLEN'(RESET_VEC);
            ret_mispred <= '0;
        end else begin
            state <= state_nxt;
            if (commit) pc <= pc_nxt;
            if (commit && mispred && (ret_mispred != '1))
                ret_mispred <= ret_mispred + 32'd1;
        end
    end

    ysyx_25030093_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (commit && bus.cmt_call),
        .pop       (commit && bus.cmt_ret),
        .push_data (pc_seq),
        .top       (ras_top),
        .valid     (ras_valid)
    );

endmodule
